// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, SPECIAL funct codes,
// divider FSM encodings and a magnitude helper for signed divide.
package ex_stage_pkg;

  localparam int FUNCT_BUS_W    = 6;
  localparam int SHAMT_BUS_W    = 5;
  localparam int DATA_BUS_W     = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int ADDR_BUS_W     = 32;
  localparam int MEM_SEL_BUS_W  = 4;

  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SLL   = 6'h00;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SRL   = 6'h02;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SRA   = 6'h03;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SLLV  = 6'h04;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SRLV  = 6'h06;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SRAV  = 6'h07;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_ADD   = 6'h20;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_ADDU  = 6'h21;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SUB   = 6'h22;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SUBU  = 6'h23;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_AND   = 6'h24;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_OR    = 6'h25;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_XOR   = 6'h26;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_NOR   = 6'h27;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SLT   = 6'h2A;
  localparam logic [FUNCT_BUS_W-1:0] FUNCT_SLTU  = 6'h2B;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [DATA_BUS_W-1:0] mag(input logic [DATA_BUS_W-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[DATA_BUS_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX register outputs into EX and EX/MEM register inputs out of EX.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [FUNCT_BUS_W-1:0]    funct_in;
  logic [SHAMT_BUS_W-1:0]    shamt_in;
  logic [DATA_BUS_W-1:0]     operand_1_in;
  logic [DATA_BUS_W-1:0]     operand_2_in;
  logic                      mem_read_flag_in;
  logic                      mem_write_flag_in;
  logic                      mem_sign_ext_flag_in;
  logic [MEM_SEL_BUS_W-1:0]  mem_sel_in;
  logic [DATA_BUS_W-1:0]     mem_write_data_in;
  logic                      write_reg_en_in;
  logic [REG_ADDR_BUS_W-1:0] write_reg_addr_in;
  logic [ADDR_BUS_W-1:0]     debug_pc_addr_in;

  logic [DATA_BUS_W-1:0]     result_out;
  logic                      mem_read_flag_out;
  logic                      mem_write_flag_out;
  logic                      mem_sign_ext_flag_out;
  logic [MEM_SEL_BUS_W-1:0]  mem_sel_out;
  logic [DATA_BUS_W-1:0]     mem_write_data_out;
  logic                      write_reg_en_out;
  logic [REG_ADDR_BUS_W-1:0] write_reg_addr_out;
  logic [ADDR_BUS_W-1:0]     debug_pc_addr_out;
  logic                      overflow_out;

  modport master (
    output funct_in, shamt_in, operand_1_in, operand_2_in,
           mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data_in, write_reg_en_in, write_reg_addr_in, debug_pc_addr_in,
    input  result_out, mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out,
           mem_sel_out, mem_write_data_out, write_reg_en_out, write_reg_addr_out,
           debug_pc_addr_out, overflow_out
  );

  modport slave (
    input  funct_in, shamt_in, operand_1_in, operand_2_in,
           mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in, mem_sel_in,
           mem_write_data_in, write_reg_en_in, write_reg_addr_in, debug_pc_addr_in,
    output result_out, mem_read_flag_out, mem_write_flag_out, mem_sign_ext_flag_out,
           mem_sel_out, mem_write_data_out, write_reg_en_out, write_reg_addr_out,
           debug_pc_addr_out, overflow_out
  );
endinterface

// File: rtl/ex_stage_div_iter.sv
// div_iter: unsigned restoring divider retiring STEP_BITS quotient bits per cycle.
// done is high during the cycle that performs the final step.
module div_iter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int unsigned ITERS = DATA_W / STEP_BITS;
  localparam int unsigned CNT_W = $clog2(ITERS);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dsr, rem_q, quo_q, rem_n, quo_n;
  logic [DATA_W:0]   trial;

  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    trial = '0;
    for (int unsigned i = 0; i < STEP_BITS; i++) begin
      trial = {rem_n, quo_n[DATA_W-1]};
      quo_n = {quo_n[DATA_W-2:0], 1'b0};
      if (trial >= {1'b0, dsr}) begin
        trial    = trial - {1'b0, dsr};
        quo_n[0] = 1'b1;
      end
      rem_n = trial[DATA_W-1:0];
    end
  end

  assign done      = busy && (cnt == CNT_W'(ITERS - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      dsr   <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      cnt   <= '0;
      dsr   <= divisor;
      rem_q <= '0;
      quo_q <= dividend;
    end else if (busy) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt   <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU/shifter, single-cycle MULT, HI/LO and iterative DIV/DIVU.
// Optional build macro: EX_DIV_EARLY_EXIT_EN (skip the divider for trivial divides).
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DIV_STEP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_current_stage,
  ex_stage_if.slave  bus,
  output logic       stall_request
);
  logic [FUNCT_BUS_W-1:0] funct;
  logic [DATA_W-1:0]      a, b, hi, lo, res, sum, diff;
  logic [2*DATA_W-1:0]    prod_s, prod_u;
  logic                   ovf;

  assign funct = bus.funct_in;
  assign a     = bus.operand_1_in;
  assign b     = bus.operand_2_in;
  assign sum   = a + b;
  assign diff  = a - b;

  assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (funct)
      FUNCT_ADD:  begin
        res = sum;
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      FUNCT_ADDU: res = sum;
      FUNCT_SUB:  begin
        res = diff;
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      FUNCT_SUBU: res = diff;
      FUNCT_AND:  res = a & b;
      FUNCT_OR:   res = a | b;
      FUNCT_XOR:  res = a ^ b;
      FUNCT_NOR:  res = ~(a | b);
      FUNCT_SLT:  res = DATA_W'($signed(a) < $signed(b));
      FUNCT_SLTU: res = DATA_W'(a < b);
      FUNCT_SLL:  res = b << bus.shamt_in;
      FUNCT_SRL:  res = b >> bus.shamt_in;
      FUNCT_SRA:  res = $signed(b) >>> bus.shamt_in;
      FUNCT_SLLV: res = b << a[4:0];
      FUNCT_SRLV: res = b >> a[4:0];
      FUNCT_SRAV: res = $signed(b) >>> a[4:0];
      FUNCT_MFHI: res = hi;
      FUNCT_MFLO: res = lo;
      default:    res = '0;
    endcase
    if (rst) res = '0;
  end

  assign bus.result_out            = res;
  assign bus.overflow_out          = ovf;
  assign bus.write_reg_en_out      = bus.write_reg_en_in & ~ovf;
  assign bus.mem_read_flag_out     = bus.mem_read_flag_in;
  assign bus.mem_write_flag_out    = bus.mem_write_flag_in;
  assign bus.mem_sign_ext_flag_out = bus.mem_sign_ext_flag_in;
  assign bus.mem_sel_out           = bus.mem_sel_in;
  assign bus.mem_write_data_out    = bus.mem_write_data_in;
  assign bus.write_reg_addr_out    = bus.write_reg_addr_in;
  assign bus.debug_pc_addr_out     = bus.debug_pc_addr_in;

  logic [1:0]        state;
  logic              is_div, div_signed_now, early_exit, div_start;
  logic              div_busy, div_done, div_written;
  logic              d_signed, d_sa, d_sb, d_zero, d_early;
  logic [DATA_W-1:0] d_raw, mag_a, mag_b, div_q, div_r, hi_new, lo_new;

  assign is_div         = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign div_signed_now = (funct == FUNCT_DIV);
  assign mag_a          = mag(a, div_signed_now);
  assign mag_b          = mag(b, div_signed_now);

`ifdef EX_DIV_EARLY_EXIT_EN
  assign early_exit = (b == '0) || (mag_a < mag_b);
`else
  assign early_exit = 1'b0;
`endif

  assign div_start     = !rst && (state == DIV_IDLE) && is_div && !early_exit;
  assign stall_request = !rst && (((state == DIV_IDLE) && is_div) || (state == DIV_BUSY));

  div_iter #(.DATA_W(DATA_W), .STEP_BITS(DIV_STEP_BITS)) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Divide-by-zero and early-exit results bypass the divider's registers entirely.
  always_comb begin
    lo_new = (d_signed && (d_sa ^ d_sb)) ? -div_q : div_q;
    hi_new = (d_signed && d_sa) ? -div_r : div_r;
    if (d_zero) begin
      lo_new = '1;
      hi_new = d_raw;
    end else if (d_early) begin
      lo_new = '0;
      hi_new = d_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DIV_IDLE;
      hi          <= '0;
      lo          <= '0;
      div_written <= 1'b0;
      d_signed    <= 1'b0;
      d_sa        <= 1'b0;
      d_sb        <= 1'b0;
      d_zero      <= 1'b0;
      d_early     <= 1'b0;
      d_raw       <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (is_div) begin
            d_signed <= div_signed_now;
            d_sa     <= a[DATA_W-1];
            d_sb     <= b[DATA_W-1];
            d_zero   <= (b == '0);
            d_early  <= early_exit;
            d_raw    <= a;
            state    <= early_exit ? DIV_DONE : DIV_BUSY;
          end else if (!stall_current_stage) begin
            case (funct)
              FUNCT_MTHI:  hi <= a;
              FUNCT_MTLO:  lo <= a;
              FUNCT_MULT:  {hi, lo} <= prod_s;
              FUNCT_MULTU: {hi, lo} <= prod_u;
              default: ;
            endcase
          end
        end
        DIV_BUSY: if (div_busy && div_done) state <= DIV_DONE;
        // The DIV stays in EX while held here; leaving only on release stops a relaunch.
        DIV_DONE: begin
          if (!div_written) begin
            hi          <= hi_new;
            lo          <= lo_new;
            div_written <= 1'b1;
          end
          if (!stall_current_stage) begin
            state       <= DIV_IDLE;
            div_written <= 1'b0;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int unsigned F_RES = 0, F_OVF = 1, F_WREN = 2, F_STALL = 3, F_SEL = 4,
                          F_PC = 5, F_WADDR = 6, F_WDATA = 7, F_FLAGS = 8;

`ifdef EX_DIV_EARLY_EXIT_EN
  localparam int unsigned TRIVIAL_DIV_STALL = 1;
`else
  localparam int unsigned TRIVIAL_DIV_STALL = 33;
`endif
  localparam int unsigned FULL_DIV_STALL = 33;

  typedef struct {
    string       name;
    int unsigned field;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst, stall_cs, stall_req;
  chk_t sb[$];
  int unsigned vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage #(.DATA_W(32), .DIV_STEP_BITS(1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_current_stage (stall_cs),
    .bus                 (bus.slave),
    .stall_request       (stall_req)
  );

  function automatic logic [31:0] actual_of(input int unsigned f);
    case (f)
      F_RES:   return bus.result_out;
      F_OVF:   return {31'b0, bus.overflow_out};
      F_WREN:  return {31'b0, bus.write_reg_en_out};
      F_STALL: return {31'b0, stall_req};
      F_SEL:   return {28'b0, bus.mem_sel_out};
      F_PC:    return bus.debug_pc_addr_out;
      F_WADDR: return {27'b0, bus.write_reg_addr_out};
      F_WDATA: return bus.mem_write_data_out;
      F_FLAGS: return {29'b0, bus.mem_read_flag_out, bus.mem_write_flag_out,
                       bus.mem_sign_ext_flag_out};
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c   = sb.pop_front();
      act = actual_of(c.field);
      vectors++;
      if (act !== c.exp) begin
        miscompares++;
        $display("FAIL %s: actual=%h required=%h", c.name, act, c.exp);
      end
    end
  end

  task automatic chk(input string n, input int unsigned f, input logic [31:0] v);
    sb.push_back('{name: n, field: f, exp: v});
  endtask

  task automatic cyc(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh = 5'd0, input logic st = 1'b0);
    @(posedge clk);
    #1;
    bus.funct_in     = f;
    bus.operand_1_in = a;
    bus.operand_2_in = b;
    bus.shamt_in     = sh;
    stall_cs         = st;
  endtask

  task automatic run_div(input string n, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int unsigned stall_cycles,
                         input int unsigned hold, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    for (int unsigned i = 0; i < stall_cycles; i++) begin
      cyc(f, a, b, 5'd0, 1'b1);
      chk({n, " stall busy"}, F_STALL, 32'd1);
    end
    for (int unsigned i = 0; i < hold; i++) begin
      cyc(f, a, b, 5'd0, 1'b1);
      chk({n, " stall held done"}, F_STALL, 32'd0);
    end
    cyc(f, a, b);
    chk({n, " stall release"}, F_STALL, 32'd0);
    cyc(FUNCT_MFLO, 32'd0, 32'd0);
    chk({n, " lo"}, F_RES, exp_lo);
    chk({n, " no relaunch"}, F_STALL, 32'd0);
    cyc(FUNCT_MFHI, 32'd0, 32'd0);
    chk({n, " hi"}, F_RES, exp_hi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst                      = 1'b1;
    stall_cs                 = 1'b0;
    bus.funct_in             = FUNCT_ADD;
    bus.shamt_in             = 5'd0;
    bus.operand_1_in         = 32'd3;
    bus.operand_2_in         = 32'd4;
    bus.mem_read_flag_in     = 1'b1;
    bus.mem_write_flag_in    = 1'b0;
    bus.mem_sign_ext_flag_in = 1'b1;
    bus.mem_sel_in           = 4'hA;
    bus.mem_write_data_in    = 32'hCAFE_F00D;
    bus.write_reg_en_in      = 1'b1;
    bus.write_reg_addr_in    = 5'h11;
    bus.debug_pc_addr_in     = 32'h0000_1234;

    @(posedge clk); #1;
    chk("rst result", F_RES, 32'd0);
    chk("rst stall", F_STALL, 32'd0);
    chk("pass sel", F_SEL, 32'hA);
    chk("pass pc", F_PC, 32'h1234);
    chk("pass waddr", F_WADDR, 32'h11);
    chk("pass wdata", F_WDATA, 32'hCAFE_F00D);
    chk("pass flags", F_FLAGS, 32'd5);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("add small", F_RES, 32'd7);

    cyc(FUNCT_MFHI, 32'd0, 32'd0);  chk("reset hi", F_RES, 32'd0);
    cyc(FUNCT_MFLO, 32'd0, 32'd0);  chk("reset lo", F_RES, 32'd0);

    cyc(FUNCT_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add ovf", F_OVF, 32'd1);
    chk("add ovf wren", F_WREN, 32'd0);
    cyc(FUNCT_ADDU, 32'h7FFF_FFFF, 32'd1);
    chk("addu result", F_RES, 32'h8000_0000);
    chk("addu wren", F_WREN, 32'd1);
    chk("addu ovf", F_OVF, 32'd0);
    cyc(FUNCT_SUB, 32'h8000_0000, 32'd1);   chk("sub ovf", F_OVF, 32'd1);
    cyc(FUNCT_SUBU, 32'h8000_0000, 32'd1);  chk("subu result", F_RES, 32'h7FFF_FFFF);

    cyc(FUNCT_SRA, 32'd0, 32'hF000_0000, 5'd4);   chk("sra", F_RES, 32'hFF00_0000);
    cyc(FUNCT_SRAV, 32'h24, 32'hF000_0000);       chk("srav", F_RES, 32'hFF00_0000);
    cyc(FUNCT_SLL, 32'd0, 32'd1, 5'd31);          chk("sll", F_RES, 32'h8000_0000);
    cyc(FUNCT_SRL, 32'd0, 32'hF000_0000, 5'd4);   chk("srl", F_RES, 32'h0F00_0000);
    cyc(FUNCT_SLLV, 32'h21, 32'd3);               chk("sllv", F_RES, 32'd6);
    cyc(FUNCT_SRLV, 32'h3F, 32'h8000_0000);       chk("srlv", F_RES, 32'd1);
    cyc(FUNCT_SLT, 32'hFFFF_FFFF, 32'd1);         chk("slt", F_RES, 32'd1);
    cyc(FUNCT_SLTU, 32'hFFFF_FFFF, 32'd1);        chk("sltu", F_RES, 32'd0);
    cyc(FUNCT_AND, 32'hF0F0, 32'hFF00);           chk("and", F_RES, 32'hF000);
    cyc(FUNCT_OR, 32'hF0F0, 32'hFF00);            chk("or", F_RES, 32'hFFF0);
    cyc(FUNCT_XOR, 32'hFF, 32'h0F);               chk("xor", F_RES, 32'hF0);
    cyc(FUNCT_NOR, 32'h0F0F_0000, 32'h00F0_000F); chk("nor", F_RES, 32'hF000_FFF0);
    cyc(6'h01, 32'd5, 32'd5);                     chk("undefined funct", F_RES, 32'd0);

    cyc(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3);
    cyc(FUNCT_MFLO, 32'd0, 32'd0);  chk("mult lo", F_RES, 32'hFFFF_FFFA);
    cyc(FUNCT_MFHI, 32'd0, 32'd0);  chk("mult hi", F_RES, 32'hFFFF_FFFF);
    cyc(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(FUNCT_MFHI, 32'd0, 32'd0);  chk("multu hi", F_RES, 32'hFFFF_FFFE);
    cyc(FUNCT_MFLO, 32'd0, 32'd0);  chk("multu lo", F_RES, 32'h0000_0001);
    cyc(FUNCT_MTHI, 32'hDEAD, 32'd0, 5'd0, 1'b1);
    cyc(FUNCT_MFHI, 32'd0, 32'd0);  chk("mthi stalled", F_RES, 32'hFFFF_FFFE);
    cyc(FUNCT_MTLO, 32'h55, 32'd0);
    cyc(FUNCT_MFLO, 32'd0, 32'd0);  chk("mtlo", F_RES, 32'h55);

    run_div("div -7/2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, FULL_DIV_STALL, 3,
            32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div 3/-7", FUNCT_DIV, 32'd3, 32'hFFFF_FFF9, TRIVIAL_DIV_STALL, 0,
            32'd0, 32'd3);
    run_div("div min/-1", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, FULL_DIV_STALL, 0,
            32'h8000_0000, 32'd0);
    run_div("divu 5/0", FUNCT_DIVU, 32'd5, 32'd0, TRIVIAL_DIV_STALL, 1,
            32'hFFFF_FFFF, 32'd5);

    cyc(FUNCT_DIV, 32'd100, 32'd7, 5'd0, 1'b1);
    chk("rst div issue stall", F_STALL, 32'd1);
    for (int unsigned i = 1; i < 10; i++) begin
      cyc(FUNCT_DIV, 32'd100, 32'd7, 5'd0, 1'b1);
      chk("rst div busy stall", F_STALL, 32'd1);
    end
    cyc(FUNCT_DIV, 32'd100, 32'd7, 5'd0, 1'b1);
    rst = 1'b1;
    chk("mid-busy rst stall", F_STALL, 32'd0);
    chk("mid-busy rst result", F_RES, 32'd0);
    cyc(FUNCT_MFHI, 32'd0, 32'd0);
    rst = 1'b0;
    chk("post rst hi", F_RES, 32'd0);
    chk("post rst stall", F_STALL, 32'd0);
    cyc(FUNCT_MFLO, 32'd0, 32'd0);
    chk("post rst lo", F_RES, 32'd0);
    run_div("div 100/7", FUNCT_DIV, 32'd100, 32'd7, FULL_DIV_STALL, 0, 32'd14, 32'd2);

    @(posedge clk); #1;
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: actual=%0d required=0", sb.size());
    end
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL vector count: actual=%0d required>=12", vectors);
    end
    if (stall_req !== 1'b0) begin
      miscompares++;
      $display("FAIL final stall: actual=%b required=0", stall_req);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) begin
      $display("FAIL summary: actual=%0d required=0", miscompares);
      $fatal(1);
    end
    $display("PASS");
    $finish;
  end
endmodule
